// File: rtl/sprime_block_fetch.sv
// Copies one 8x8 block of 16-bit S' coefficients from SRAM into the IDCT DPRAM,
// sign-extending each word to 32 bits on the way through.
module sprime_block_fetch #(
   parameter logic [17:0] Y_BASE  = 18'd76800,
   parameter logic [17:0] U_BASE  = 18'd153600,
   parameter logic [17:0] V_BASE  = 18'd192000,
   parameter logic [8:0]  DP_BASE = 9'd0
) (
   input  logic        CLOCK_50_I,
   input  logic        resetn,
   input  logic        start,
   input  logic [1:0]  plane,
   input  logic [5:0]  block_col,
   input  logic [4:0]  block_row,
   output logic [17:0] SRAM_address,
   output logic        SRAM_we_n,
   output logic [15:0] SRAM_write_data,
   input  logic [15:0] SRAM_read_data,
   output logic [8:0]  DP_address,
   output logic [31:0] DP_write_data,
   output logic        DP_write_en,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t      state_reg, state_next;
   logic [1:0]  plane_reg;
   logic [5:0]  col_reg;
   logic [4:0]  row_reg;
   logic        err_reg;
   logic [5:0]  cnt_reg;
   logic        drain_reg;
   logic [17:0] addr_hold_reg;
   logic        p1_valid_reg;
   logic [5:0]  p1_idx_reg;

   logic        req_ok;
   logic [7:0]  row_line;
   logic [17:0] line_ext;
   logic [17:0] line_off;
   logic [17:0] col_off;
   logic [17:0] base_sel;
   logic [17:0] addr_calc;

   // Request validation works on the live inputs; only meaningful in IDLE.
   always_comb begin
      req_ok = 1'b0;
      case (plane)
         2'd0:    req_ok = (block_row <= 5'd29) && (block_col <= 6'd39);
         2'd1,
         2'd2:    req_ok = (block_row <= 5'd29) && (block_col <= 6'd19);
         default: req_ok = 1'b0;
      endcase
   end

   // Picture line = row*8 + r; strides 320 and 160 are built from shift-adds.
   assign row_line = {row_reg, cnt_reg[5:3]};
   assign line_ext = {10'd0, row_line};
   assign col_off  = {9'd0, col_reg, cnt_reg[2:0]};

   always_comb begin
      base_sel = Y_BASE;
      line_off = (line_ext << 8) + (line_ext << 6);
      case (plane_reg)
         2'd1: begin
            base_sel = U_BASE;
            line_off = (line_ext << 7) + (line_ext << 5);
         end
         2'd2: begin
            base_sel = V_BASE;
            line_off = (line_ext << 7) + (line_ext << 5);
         end
         default: begin
            base_sel = Y_BASE;
            line_off = (line_ext << 8) + (line_ext << 6);
         end
      endcase
   end

   assign addr_calc = base_sel + line_off + col_off;

   // Address is live during READ so element 0 goes out in the cycle right after start.
   assign SRAM_address    = (state_reg == S_READ) ? addr_calc : addr_hold_reg;
   assign SRAM_we_n       = 1'b1;
   assign SRAM_write_data = 16'd0;

   assign DP_write_data = {{16{SRAM_read_data[15]}}, SRAM_read_data};

   assign busy = (state_reg != S_IDLE);
   assign done = (state_reg == S_DONE);
   assign err  = (state_reg == S_DONE) && err_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = req_ok ? S_READ : S_DONE;
            end
         end
         S_READ: begin
            if (cnt_reg == 6'd63) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_reg) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Request latch and issue-side counters.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         plane_reg     <= 2'd0;
         col_reg       <= 6'd0;
         row_reg       <= 5'd0;
         err_reg       <= 1'b0;
         cnt_reg       <= 6'd0;
         drain_reg     <= 1'b0;
         addr_hold_reg <= 18'd0;
      end else begin
         if ((state_reg == S_IDLE) && start) begin
            plane_reg <= plane;
            col_reg   <= block_col;
            row_reg   <= block_row;
            err_reg   <= !req_ok;
         end
         if (state_reg == S_READ) begin
            cnt_reg       <= cnt_reg + 6'd1;
            addr_hold_reg <= addr_calc;
         end else begin
            cnt_reg <= 6'd0;
         end
         drain_reg <= (state_reg == S_DRAIN) ? !drain_reg : 1'b0;
      end
   end

   // Two-stage delay of the issue index lines the DPRAM write up with the SRAM latency.
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         p1_valid_reg <= 1'b0;
         p1_idx_reg   <= 6'd0;
         DP_write_en  <= 1'b0;
         DP_address   <= 9'd0;
      end else begin
         p1_valid_reg <= (state_reg == S_READ);
         p1_idx_reg   <= cnt_reg;
         DP_write_en  <= p1_valid_reg;
         if (p1_valid_reg) begin
            DP_address <= DP_BASE + {3'd0, p1_idx_reg};
         end
      end
   end

endmodule

// File: tb/tb_sprime_block_fetch.sv
// Directed bench for sprime_block_fetch: 2-cycle-latency SRAM model, DPRAM capture,
// and immediate-assertion checks against hand-computed values.
module tb_sprime_block_fetch;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [1:0]  plane;
   logic [5:0]  block_col;
   logic [4:0]  block_row;
   logic [17:0] SRAM_address;
   logic        SRAM_we_n;
   logic [15:0] SRAM_write_data;
   logic [15:0] SRAM_read_data;
   logic [8:0]  DP_address;
   logic [31:0] DP_write_data;
   logic        DP_write_en;
   logic        busy;
   logic        done;
   logic        err;

   always #10 clk = ~clk;

   sprime_block_fetch dut (
      .CLOCK_50_I      (clk),
      .resetn          (resetn),
      .start           (start),
      .plane           (plane),
      .block_col       (block_col),
      .block_row       (block_row),
      .SRAM_address    (SRAM_address),
      .SRAM_we_n       (SRAM_we_n),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_read_data  (SRAM_read_data),
      .DP_address      (DP_address),
      .DP_write_data   (DP_write_data),
      .DP_write_en     (DP_write_en),
      .busy            (busy),
      .done            (done),
      .err             (err)
   );

   // SRAM contents: mode 0 -> word = address[15:0]; mode 1 -> every word 0xFFF8.
   int mode;
   logic [15:0] sram_d1;

   function automatic logic [15:0] mem_f(input logic [17:0] a);
      if (mode == 1) return 16'hFFF8;
      return a[15:0];
   endfunction

   always @(posedge clk) begin
      sram_d1        <= mem_f(SRAM_address);
      SRAM_read_data <= sram_d1;
   end

   function automatic logic [17:0] exp_addr(input int p, input int c, input int r, input int i);
      int base;
      int stride;
      int v;
      base   = (p == 0) ? 76800 : ((p == 1) ? 153600 : 192000);
      stride = (p == 0) ? 320 : 160;
      v      = base + (r * 8 + i / 8) * stride + c * 8 + i % 8;
      return v[17:0];
   endfunction

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Observation record for one request.
   int          wr_cnt, first_wr, last_wr, done_cnt, done_cyc, dup_cnt, range_bad;
   int          busy_cyc, addr_changes;
   logic        err_at_done;
   logic [17:0] addr_before, addr_c1, addr_c64;
   logic [31:0] dpm [0:63];
   logic        seen [0:63];

   // Launch one request, then watch cycles 1..ncyc after the start edge.
   // A second start (plane p2, col 0, row 0) is pulsed in cycles s1 and s2.
   task automatic run(input int p, input int c, input int r, input int ncyc,
                      input int s1, input int s2, input logic [1:0] p2);
      int idx;
      wr_cnt = 0; first_wr = -1; last_wr = -1; done_cnt = 0; done_cyc = -1;
      dup_cnt = 0; range_bad = 0; busy_cyc = 0; addr_changes = 0; err_at_done = 1'bx;
      for (int i = 0; i < 64; i++) begin
         dpm[i]  = 32'hxxxxxxxx;
         seen[i] = 1'b0;
      end
      plane       = p[1:0];
      block_col   = c[5:0];
      block_row   = r[4:0];
      addr_before = SRAM_address;
      start       = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      plane     = 2'd3;
      block_col = 6'd63;
      block_row = 5'd31;
      for (int k = 1; k <= ncyc; k++) begin
         if (DP_write_en) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = k;
            last_wr = k;
            idx = int'(DP_address);
            if (idx > 63) begin
               range_bad++;
            end else begin
               if (seen[idx]) dup_cnt++;
               seen[idx] = 1'b1;
               dpm[idx]  = DP_write_data;
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc    = k;
            err_at_done = err;
         end
         if (busy) busy_cyc++;
         if (SRAM_address != addr_before) addr_changes++;
         if (k == 1)  addr_c1  = SRAM_address;
         if (k == 64) addr_c64 = SRAM_address;
         if (k == s1 || k == s2) begin
            start     = 1'b1;
            plane     = p2;
            block_col = 6'd0;
            block_row = 5'd0;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   task automatic check_block(input string tag, input int p, input int c, input int r);
      int bad;
      logic [15:0] w;
      logic [31:0] e;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         w = mem_f(exp_addr(p, c, r, i));
         e = {{16{w[15]}}, w};
         if (dpm[i] !== e) bad++;
      end
      check(tag, 32'(bad), 32'd0);
   endtask

   task automatic check_valid_timing(input string tag);
      check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd64);
      check({tag, "_first_wr"}, 32'(first_wr), 32'd3);
      check({tag, "_last_wr"}, 32'(last_wr), 32'd66);
      check({tag, "_dup"}, 32'(dup_cnt + range_bad), 32'd0);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_cyc"}, 32'(done_cyc), 32'd67);
      check({tag, "_err"}, 32'(err_at_done), 32'd0);
      check({tag, "_busy_cyc"}, 32'(busy_cyc), 32'd67);
   endtask

   task automatic check_invalid(input string tag);
      check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check({tag, "_done_cyc"}, 32'(done_cyc), 32'd1);
      check({tag, "_err"}, 32'(err_at_done), 32'd1);
      check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd0);
      check({tag, "_addr_moved"}, 32'(addr_changes), 32'd0);
      check({tag, "_busy_cyc"}, 32'(busy_cyc), 32'd1);
   endtask

   initial begin
      resetn    = 1'b0;
      start     = 1'b0;
      plane     = 2'd0;
      block_col = 6'd0;
      block_row = 5'd0;
      mode      = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sram_addr", 32'(SRAM_address), 32'd0);
      check("rst_we_n", 32'(SRAM_we_n), 32'd1);
      check("rst_wdata", 32'(SRAM_write_data), 32'd0);
      check("rst_dp_addr", 32'(DP_address), 32'd0);
      check("rst_dp_we", 32'(DP_write_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Y block (0,0), data = address
      run(0, 0, 0, 75, 0, 0, 2'd0);
      $display("txn Y(0,0): writes=%0d done_cyc=%0d first_addr=%0d", wr_cnt, done_cyc, addr_c1);
      check("y00_addr0", 32'(addr_c1), 32'd76800);
      check("y00_word0", dpm[0], 32'h00002C00);
      check("y00_word9", dpm[9], 32'h00002D41);
      check_valid_timing("y00");
      check_block("y00_block", 0, 0, 0);

      // U block at the far corner; inputs scrambled after the start edge
      run(1, 19, 29, 75, 0, 0, 2'd0);
      $display("txn U(19,29): writes=%0d first_addr=%0d last_addr=%0d", wr_cnt, addr_c1, addr_c64);
      check("u1929_addr0", 32'(addr_c1), 32'd190872);
      check("u1929_addr63", 32'(addr_c64), 32'd191999);
      check("u1929_word63", dpm[63], 32'hFFFFEDFF);
      check_valid_timing("u1929");
      check_block("u1929_block", 1, 19, 29);

      // Negative data, largest Y block
      mode = 1;
      run(0, 39, 29, 75, 0, 0, 2'd0);
      $display("txn Y(39,29) neg: writes=%0d last_addr=%0d", wr_cnt, addr_c64);
      check("yneg_addr63", 32'(addr_c64), 32'd153599);
      check("yneg_word0", dpm[0], 32'hFFFFFFF8);
      check_valid_timing("yneg");
      check_block("yneg_block", 0, 39, 29);
      mode = 0;

      // V block (0,0)
      run(2, 0, 0, 75, 0, 0, 2'd0);
      $display("txn V(0,0): writes=%0d first_addr=%0d", wr_cnt, addr_c1);
      check("v00_addr0", 32'(addr_c1), 32'd192000);
      check("v00_word0", dpm[0], 32'hFFFFEE00);
      check_block("v00_block", 2, 0, 0);

      // Rejected requests
      run(3, 0, 0, 5, 0, 0, 2'd0);
      $display("txn invalid plane=3: done_cyc=%0d err=%0b writes=%0d", done_cyc, err_at_done, wr_cnt);
      check_invalid("inv_p3");
      run(1, 20, 0, 5, 0, 0, 2'd0);
      $display("txn invalid U col=20: done_cyc=%0d err=%0b writes=%0d", done_cyc, err_at_done, wr_cnt);
      check_invalid("inv_ucol");
      run(0, 40, 0, 5, 0, 0, 2'd0);
      $display("txn invalid Y col=40: done_cyc=%0d err=%0b writes=%0d", done_cyc, err_at_done, wr_cnt);
      check_invalid("inv_ycol");
      run(2, 0, 30, 5, 0, 0, 2'd0);
      $display("txn invalid V row=30: done_cyc=%0d err=%0b writes=%0d", done_cyc, err_at_done, wr_cnt);
      check_invalid("inv_row");

      // Starts while busy (cycle 10) and in the done cycle (67) are ignored
      run(0, 2, 1, 75, 10, 67, 2'd1);
      $display("txn Y(2,1) with extra starts: writes=%0d done_pulses=%0d busy_cyc=%0d", wr_cnt, done_cnt, busy_cyc);
      check_valid_timing("busy_st");
      check_block("busy_st_block", 0, 2, 1);

      // Reset in the middle of a fetch
      run(0, 3, 4, 29, 0, 0, 2'd0);
      check("mid_wr_before_rst", 32'(wr_cnt), 32'd27);
      resetn = 1'b0;
      #1;
      $display("txn reset at cycle 30: dp_we=%0b busy=%0b sram_addr=%0d", DP_write_en, busy, SRAM_address);
      check("mid_rst_dp_we", 32'(DP_write_en), 32'd0);
      check("mid_rst_dp_addr", 32'(DP_address), 32'd0);
      check("mid_rst_sram_addr", 32'(SRAM_address), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      run(0, 3, 4, 75, 0, 0, 2'd0);
      $display("txn Y(3,4) after reset: writes=%0d done_cyc=%0d", wr_cnt, done_cyc);
      check_valid_timing("post_rst");
      check_block("post_rst_block", 0, 3, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
